// File: rtl/ctrl_fsm_if.sv
// Control bundle between ctrl_fsm and the 16-bit datapath.
// master = control unit, slave = datapath.
interface ctrl_fsm_if;
  logic [15:0] IR;
  logic        PC_clr;
  logic        PC_up;
  logic        IR_ld;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  CurrentState;

  modport master (
    input  IR,
    output PC_clr, PC_up, IR_ld,
    output D_addr, D_wr, RF_s,
    output RF_W_addr, RF_W_en,
    output RF_Ra_addr, RF_Rb_addr,
    output ALU_s0, CurrentState
  );

  modport slave (
    output IR,
    input  PC_clr, PC_up, IR_ld,
    input  D_addr, D_wr, RF_s,
    input  RF_W_addr, RF_W_en,
    input  RF_Ra_addr, RF_Rb_addr,
    input  ALU_s0, CurrentState
  );
endinterface

// File: rtl/ctrl_fsm.sv
// Fetch/decode/execute control unit for the 16-bit datapath.
// CTRL_HALT_EN: opcode 0101 parks the FSM in HALT until reset.
module ctrl_fsm (
  input  logic        Clock,
  input  logic        Resetn,
  ctrl_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8
`ifdef CTRL_HALT_EN
    , S_HALT = 4'd9
`endif
  } state_e;

  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
`ifdef CTRL_HALT_EN
  localparam logic [3:0] OP_HALT  = 4'b0101;
`endif

  state_e state_q;
  state_e state_d;
  state_e dec_st;

  logic [3:0] op;
  assign op = bus.IR[15:12];

  // reserved opcodes fall through to the NOOP path
  always_comb begin
    dec_st = S_NOOP;
    unique case (1'b1)
      (op == OP_STORE): dec_st = S_STORE;
      (op == OP_LOAD):  dec_st = S_LOAD_A;
      (op == OP_ADD):   dec_st = S_ADD;
      (op == OP_SUB):   dec_st = S_SUB;
`ifdef CTRL_HALT_EN
      (op == OP_HALT):  dec_st = S_HALT;
`endif
      default:          dec_st = S_NOOP;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_INIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d        = S_INIT;
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.IR_ld      = 1'b0;
    bus.D_addr     = 8'd0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_addr  = 4'd0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = 4'd0;
    bus.RF_Rb_addr = 4'd0;
    bus.ALU_s0     = 3'b000;
    bus.CurrentState = state_q;
    unique case (state_q)
      S_INIT: begin
        bus.PC_clr = 1'b1;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        bus.IR_ld = 1'b1;
        bus.PC_up = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: state_d = dec_st;
      S_NOOP:   state_d = S_FETCH;
      S_LOAD_A: begin
        bus.D_addr    = bus.IR[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = bus.IR[3:0];
        state_d       = S_LOAD_B;
      end
      S_LOAD_B: begin
        bus.D_addr    = bus.IR[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = bus.IR[3:0];
        bus.RF_W_en   = 1'b1;
        state_d       = S_FETCH;
      end
      S_STORE: begin
        bus.D_addr     = bus.IR[11:4];
        bus.RF_Ra_addr = bus.IR[3:0];
        bus.D_wr       = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADD, S_SUB: begin
        bus.RF_Ra_addr = bus.IR[11:8];
        bus.RF_Rb_addr = bus.IR[7:4];
        bus.RF_W_addr  = bus.IR[3:0];
        bus.RF_W_en    = 1'b1;
        bus.ALU_s0     = (state_q == S_SUB) ? 3'b010 : 3'b001;
        state_d        = S_FETCH;
      end
`ifdef CTRL_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed program plus random
// instruction stream against a per-instruction cycle model.
module tb_ctrl_fsm;

  logic clk;
  logic rst_n;
  ctrl_fsm_if bus ();

  ctrl_fsm dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  typedef logic [32:0] vec_t;

  int   n_cmp;
  int   n_err;
  vec_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  function automatic vec_t pack(
    input logic pc_clr, input logic pc_up, input logic ir_ld,
    input logic [7:0] d_addr, input logic d_wr, input logic rf_s,
    input logic [3:0] waddr, input logic wen,
    input logic [3:0] ra, input logic [3:0] rb,
    input logic [2:0] alu, input logic [3:0] st);
    return {pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s,
            waddr, wen, ra, rb, alu, st};
  endfunction

  function automatic vec_t dut_vec();
    return pack(bus.PC_clr, bus.PC_up, bus.IR_ld, bus.D_addr,
                bus.D_wr, bus.RF_s, bus.RF_W_addr, bus.RF_W_en,
                bus.RF_Ra_addr, bus.RF_Rb_addr, bus.ALU_s0,
                bus.CurrentState);
  endfunction

  task automatic chk(input string tag, input vec_t got,
                     input vec_t want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               tag, got, want, $time);
    end
  endtask

  vec_t v_init;
  vec_t v_fetch;
  vec_t v_dec;

  // Expected per-cycle outputs for one instruction, FETCH onward.
  task automatic build(input logic [15:0] ir);
    logic [3:0] op;
    op = ir[15:12];
    exp_q.delete();
    exp_q.push_back(v_fetch);
    exp_q.push_back(v_dec);
    if (op == 4'd1) begin
      exp_q.push_back(pack(0, 0, 0, ir[11:4], 1, 0, 0, 0,
                           ir[3:0], 0, 0, 4'd6));
    end else if (op == 4'd2) begin
      exp_q.push_back(pack(0, 0, 0, ir[11:4], 0, 1, ir[3:0], 0,
                           0, 0, 0, 4'd4));
      exp_q.push_back(pack(0, 0, 0, ir[11:4], 0, 1, ir[3:0], 1,
                           0, 0, 0, 4'd5));
    end else if (op == 4'd3 || op == 4'd4) begin
      exp_q.push_back(pack(0, 0, 0, 0, 0, 0, ir[3:0], 1,
                           ir[11:8], ir[7:4],
                           (op == 4'd3) ? 3'b001 : 3'b010,
                           (op == 4'd3) ? 4'd7 : 4'd8));
`ifdef CTRL_HALT_EN
    end else if (op == 4'd5) begin
      // HALT cycles are checked by the caller
`endif
    end else begin
      exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd3));
    end
  endtask

  task automatic run_instr(input logic [15:0] ir, input string nm,
                           input int ncyc);
    int k;
    vec_t e;
    build(ir);
    k = 0;
    while (exp_q.size() > 0 && (ncyc == 0 || k < ncyc)) begin
      e = exp_q.pop_front();
      @(negedge clk);
      chk($sformatf("%s_c%0d", nm, k), dut_vec(), e);
      if (bus.IR_ld) begin
        @(posedge clk);
        #1 bus.IR = ir;
      end
      k++;
    end
  endtask

  task automatic reset_pulse(input string nm);
    #2 rst_n = 1'b0;
    #1 chk({nm, "_async"}, dut_vec(), v_init);
    repeat (2) begin
      @(negedge clk);
      chk({nm, "_hold"}, dut_vec(), v_init);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] ir;
    n_cmp   = 0;
    n_err   = 0;
    v_init  = pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    v_fetch = pack(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd1);
    v_dec   = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd2);
    bus.IR  = 16'h0000;
    rst_n   = 1'b0;

    repeat (2) begin
      @(negedge clk);
      chk("reset", dut_vec(), v_init);
    end
    rst_n = 1'b1;

    run_instr(16'h3125, "add", 0);
    run_instr(16'h2AB3, "load", 0);
    run_instr(16'h1C47, "store", 0);
    run_instr(16'h4321, "sub", 0);
    run_instr(16'hF000, "resv", 0);

    run_instr(16'h2AB3, "midload", 3);
    reset_pulse("rst_load");
    run_instr(16'h0000, "after_rst", 0);

`ifdef CTRL_HALT_EN
    run_instr(16'h5000, "halt", 2);
    repeat (20) begin
      @(negedge clk);
      chk("halt_hold", dut_vec(),
          pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd9));
    end
    reset_pulse("rst_halt");
`else
    run_instr(16'h5000, "halt_noop", 0);
`endif

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
`ifdef CTRL_HALT_EN
      if (op == 4'd5) op = 4'd0;
`endif
      ir = {op, 12'($urandom)};
      run_instr(ir, $sformatf("rnd%0d_%h", i, ir), 0);
    end

    run_instr(16'h0000, "tail", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
